tensor_cpu: RTL and testbench
=============================

Name: tensor_cpu

Overview:
- Single-cycle 8-bit CPU with 8 general registers R0-R7 and a tensor-core register file of 18 signed 8-bit registers T0-T17.
- T0-T8 form 3x3 matrix A and T9-T17 form 3x3 matrix B, both row-major.
- Executes one 16-bit instruction per clock from an external sequencer; includes a one-cycle 3x3 matrix multiply.
- Results are reported on a registered output bus.

Parameters:
- BUS_WIDTH, 8, data width of every register and of cpu_output.
- NUM_CPU_REGS, 8, number of general registers (3-bit address).
- NUM_TENSOR_REGS, 18, number of tensor registers (5-bit address).

Ports:
- clock_in  input  1  system clock; all state updates on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- current_instruction  input  16  instruction sampled on every rising edge.
- cpu_output  output  8 (signed)  registered result/readback bus.
- tensor_done  output  1  high once a matrix multiply has completed.

Behaviour:
- Opcode is bits [15:12]. rd=[11:9], rs1=[8:6], rs2=[5:3].
- Tensor address fields: ta=[11:7], tb=[6:2], tc=[8:4].
- Reset (reset_in=1 at an edge): all R, all T, cpu_output and tensor_done become 0. Reset overrides the current instruction.
- 0000 ADD: R[rd]<=R[rs1]+R[rs2].
- 0001 SUB: R[rd]<=R[rs1]-R[rs2].
- 0010 MUL: R[rd]<=low 8 bits of R[rs1]*R[rs2].
- ADD, SUB and MUL wrap two's complement.
- 0011 EQL: R[rd]<=(R[rs1]==R[rs2])?1:0.
- 0100 GRT: R[rd]<=(signed R[rs1]>R[rs2])?1:0.
- All ALU ops also load the result into cpu_output.
- 1010 ADD_IMM: R[rd]<=R[rd]+imm8[7:0] (wrap); cpu_output<=result; bit 8 ignored.
- 0101 TENSOR_CORE_OPERATE: computes A<=A*B.
  - Each element is the sum over k of A[i][k]*B[k][j], computed at full precision, then truncated to 8 bits (wrap).
  - All nine elements are computed from pre-edge values and written on the same edge.
  - tensor_done<=1 on that edge. B is unchanged.
- 0110 TENSOR_CORE_LOAD: T[ta]<=sign-extended imm7 [6:0].
- 0111 CPU_TO_TENSOR_CORE: T[ta]<=R[[6:4]].
- 1000 TENSOR_CORE_TO_CPU: R[rd]<=T[tc]; cpu_output<=same value.
- 1001 NOP: no state change.
- 1011 MOVE_CPU: R[rd]<=R[rs1].
- 1100 MOVE_TENSOR_CORE: T[ta]<=T[tb].
- 1101 RESET: same effect as reset_in for one cycle.
- 1110 READ_CPU: cpu_output<=R[rd].
- 1111 READ_TENSOR_CORE: cpu_output<=T[ta].
- Instructions not listed as updating cpu_output hold its value.
- Any instruction that writes a tensor register (other than OPERATE) clears tensor_done.
- Tensor addresses 18-31: writes are ignored; reads return 0.
- Latency: an instruction is sampled at edge N and its effects are visible after edge N. Back-to-back dependent instructions must work: the instruction at edge N+1 sees values written at edge N.
- All operand reads use pre-edge register values. For example, ADD R1,R1,R1 doubles R1.

Optional Feature:
- Macro TENSOR_SATURATE_EN.
- When defined: each OPERATE dot product saturates to [-128,127] instead of wrapping.
- When undefined: wrap (truncate to low 8 bits).
- ALU arithmetic always wraps in both cases.

Test Plan:
- Reset, then READ_CPU R0 and READ_TENSOR_CORE T17 -> cpu_output=0, tensor_done=0.
- ADD_IMM R1,+5; ADD_IMM R2,-3 (0xFD); ADD R3,R1,R2; GRT R4,R1,R2 -> cpu_output 5, -3, 2, 1.
- ADD_IMM R1,100; MUL R5,R1,R1 after R1=100 -> 10000 mod 256 = 16.
  - With TENSOR_SATURATE_EN, OPERATE on all-50 matrices -> each element 127; without it -> 7500 mod 256 = 76.
- Load A=[1..9] and B=identity via TENSOR_CORE_LOAD; OPERATE; READ T4 -> 5, tensor_done=1; next TENSOR_CORE_LOAD clears tensor_done.
- Load A=[1,2,3;4,5,6;7,8,9] and B=[1..9]; OPERATE; read T0,T4,T8 -> 30, 81, 150 (wrapped to -106 as signed 8-bit).
- MOVE_CPU, CPU_TO_TENSOR_CORE T20, TENSOR_CORE_TO_CPU T20 -> value 0, nothing written.
  - RESET opcode mid-program zeroes all registers.
  - reset_in together with ADD leaves the destination at 0.

Source files
------------

// File: rtl/tensor_cpu.sv
// Single-cycle 8-bit CPU with a 3x3 tensor core (A = T0-T8, B = T9-T17).
// Define TENSOR_SATURATE_EN to saturate OPERATE dot products instead of wrapping.
module tensor_cpu #(
   parameter int unsigned BUS_WIDTH       = 8,
   parameter int unsigned NUM_CPU_REGS    = 8,
   parameter int unsigned NUM_TENSOR_REGS = 18
) (
   input  logic                        clock_in,
   input  logic                        reset_in,
   input  logic [15:0]                 current_instruction,
   output logic signed [BUS_WIDTH-1:0] cpu_output,
   output logic                        tensor_done
);

   typedef logic signed [BUS_WIDTH-1:0] word_t;

   typedef enum logic [3:0] {
      OpAdd    = 4'h0, OpSub   = 4'h1, OpMul    = 4'h2, OpEql   = 4'h3,
      OpGrt    = 4'h4, OpTOper = 4'h5, OpTLoad  = 4'h6, OpCpuToT = 4'h7,
      OpTToCpu = 4'h8, OpNop   = 4'h9, OpAddImm = 4'hA, OpMovCpu = 4'hB,
      OpMovT   = 4'hC, OpRst   = 4'hD, OpRdCpu  = 4'hE, OpRdT   = 4'hF
   } opcode_e;

`ifdef TENSOR_SATURATE_EN
   localparam int unsigned AccW = 2 * BUS_WIDTH + 2;
`else
   localparam int unsigned AccW = BUS_WIDTH;
`endif

   word_t   r_q [NUM_CPU_REGS];
   word_t   r_d [NUM_CPU_REGS];
   word_t   t_q [NUM_TENSOR_REGS];
   word_t   t_d [NUM_TENSOR_REGS];
   word_t   out_q, out_d;
   logic    done_q, done_d;
   word_t   mat_res [9];
   word_t   alu_res;
   opcode_e op;
   logic [2:0] rd, rs1, rs2;
   logic [4:0] ta, tb, tc;

   assign op  = opcode_e'(current_instruction[15:12]);
   assign rd  = current_instruction[11:9];
   assign rs1 = current_instruction[8:6];
   assign rs2 = current_instruction[5:3];
   assign ta  = current_instruction[11:7];
   assign tb  = current_instruction[6:2];
   assign tc  = current_instruction[8:4];

   function automatic word_t t_read(input logic [4:0] addr);
      if (addr < 5'(NUM_TENSOR_REGS)) return t_q[addr];
      return '0;
   endfunction

   // Dot products use pre-edge A and B; AccW is wide enough only when saturating.
   for (genvar i = 0; i < 3; i++) begin : g_row
      for (genvar j = 0; j < 3; j++) begin : g_col
         logic signed [AccW-1:0] dot;
         assign dot = AccW'(t_q[i*3])     * AccW'(t_q[9+j])
                    + AccW'(t_q[i*3 + 1]) * AccW'(t_q[12+j])
                    + AccW'(t_q[i*3 + 2]) * AccW'(t_q[15+j]);
`ifdef TENSOR_SATURATE_EN
         localparam logic signed [AccW-1:0] SatMax = AccW'(2 ** (BUS_WIDTH - 1) - 1);
         localparam logic signed [AccW-1:0] SatMin = -SatMax - AccW'(1);
         assign mat_res[i*3 + j] = (dot > SatMax) ? {1'b0, {(BUS_WIDTH - 1){1'b1}}} :
                                   (dot < SatMin) ? {1'b1, {(BUS_WIDTH - 1){1'b0}}} :
                                   dot[BUS_WIDTH-1:0];
`else
         assign mat_res[i*3 + j] = dot;
`endif
      end
   end

   always_comb begin
      r_d     = r_q;
      t_d     = t_q;
      out_d   = out_q;
      done_d  = done_q;
      alu_res = '0;
      case (op)
         OpAdd, OpSub, OpMul, OpEql, OpGrt, OpAddImm: begin
            case (op)
               OpAdd:   alu_res = r_q[rs1] + r_q[rs2];
               OpSub:   alu_res = r_q[rs1] - r_q[rs2];
               OpMul:   alu_res = r_q[rs1] * r_q[rs2];
               OpEql:   alu_res = (r_q[rs1] == r_q[rs2]) ? word_t'(1) : '0;
               OpGrt:   alu_res = (r_q[rs1] > r_q[rs2]) ? word_t'(1) : '0;
               default: alu_res = r_q[rd] + word_t'(current_instruction[7:0]);
            endcase
            r_d[rd] = alu_res;
            out_d   = alu_res;
         end
         OpTOper: begin
            for (int unsigned n = 0; n < 9; n++) t_d[n[4:0]] = mat_res[n[3:0]];
            done_d = 1'b1;
         end
         OpTLoad, OpCpuToT, OpMovT: begin
            if (ta < 5'(NUM_TENSOR_REGS)) begin
               case (op)
                  OpTLoad:  t_d[ta] = word_t'({{(BUS_WIDTH - 7){current_instruction[6]}},
                                               current_instruction[6:0]});
                  OpCpuToT: t_d[ta] = r_q[current_instruction[6:4]];
                  default:  t_d[ta] = t_read(tb);
               endcase
            end
            done_d = 1'b0;
         end
         OpTToCpu: begin
            r_d[rd] = t_read(tc);
            out_d   = t_read(tc);
         end
         OpMovCpu: r_d[rd] = r_q[rs1];
         OpRdCpu:  out_d   = r_q[rd];
         OpRdT:    out_d   = t_read(ta);
         default:  ;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset_in || op == OpRst) begin
         r_q    <= '{default: '0};
         t_q    <= '{default: '0};
         out_q  <= '0;
         done_q <= 1'b0;
      end else begin
         r_q    <= r_d;
         t_q    <= t_d;
         out_q  <= out_d;
         done_q <= done_d;
      end
   end

   assign cpu_output  = out_q;
   assign tensor_done = done_q;

endmodule

// File: tb/tb_tensor_cpu.sv
// Directed self-checking bench for tensor_cpu; honours TENSOR_SATURATE_EN when defined.
module tb_tensor_cpu;

   logic               clk = 1'b0;
   logic               rst;
   logic [15:0]        instr;
   logic signed [7:0]  cpu_out;
   logic               done;
   int                 tests = 0;
   int                 fails = 0;

`ifdef TENSOR_SATURATE_EN
   localparam logic [7:0] ExpAll50 = 8'd127;
   localparam logic [7:0] ExpT8    = 8'd127;
`else
   localparam logic [7:0] ExpAll50 = 8'd76;
   localparam logic [7:0] ExpT8    = 8'h96;
`endif

   tensor_cpu dut (
      .clock_in            (clk),
      .reset_in            (rst),
      .current_instruction (instr),
      .cpu_output          (cpu_out),
      .tensor_done         (done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] alu(input logic [3:0] op, input logic [2:0] d,
                                       input logic [2:0] a, input logic [2:0] b);
      return {op, d, a, b, 3'b000};
   endfunction
   function automatic logic [15:0] addi(input logic [2:0] d, input logic [7:0] imm);
      return {4'hA, d, 1'b0, imm};
   endfunction
   function automatic logic [15:0] tload(input logic [4:0] a, input logic [6:0] imm);
      return {4'h6, a, imm};
   endfunction
   function automatic logic [15:0] c2t(input logic [4:0] a, input logic [2:0] s);
      return {4'h7, a, s, 4'b0000};
   endfunction
   function automatic logic [15:0] t2c(input logic [2:0] d, input logic [4:0] c);
      return {4'h8, d, c, 4'b0000};
   endfunction
   function automatic logic [15:0] mvt(input logic [4:0] a, input logic [4:0] b);
      return {4'hC, a, b, 2'b00};
   endfunction
   function automatic logic [15:0] rdc(input logic [2:0] d);
      return {4'hE, d, 9'd0};
   endfunction
   function automatic logic [15:0] rdt(input logic [4:0] a);
      return {4'hF, a, 7'd0};
   endfunction

   localparam logic [15:0] Nop  = 16'h9000;
   localparam logic [15:0] Oper = 16'h5000;
   localparam logic [15:0] Rst  = 16'hD000;

   task automatic step(input logic [15:0] i);
      @(negedge clk);
      instr = i;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d (0x%02h) expected %0d (0x%02h)", tag, obs, obs, exp, exp);
      end
   endtask

   initial begin
      rst   = 1'b1;
      instr = alu(4'h0, 3'd1, 3'd1, 3'd1);
      step(instr);
      step(instr);
      rst = 1'b0;

      step(rdc(3'd0));                    check("reset_r0", cpu_out, 8'd0);
      check("reset_done", {7'd0, done}, 8'd0);
      step(rdt(5'd17));                   check("reset_t17", cpu_out, 8'd0);

      step(addi(3'd1, 8'd5));             check("addi_r1", cpu_out, 8'd5);
      step(addi(3'd2, 8'hFD));            check("addi_r2_neg", cpu_out, 8'hFD);
      step(alu(4'h0, 3'd3, 3'd1, 3'd2));  check("add_r3", cpu_out, 8'd2);
      step(alu(4'h4, 3'd4, 3'd1, 3'd2));  check("grt_signed", cpu_out, 8'd1);
      step(alu(4'h4, 3'd4, 3'd2, 3'd1));  check("grt_false", cpu_out, 8'd0);
      step(alu(4'h1, 3'd6, 3'd2, 3'd1));  check("sub_r6", cpu_out, 8'hF8);
      step(alu(4'h3, 3'd7, 3'd1, 3'd1));  check("eql_true", cpu_out, 8'd1);
      step(alu(4'h3, 3'd7, 3'd1, 3'd2));  check("eql_false", cpu_out, 8'd0);
      step(addi(3'd1, 8'd95));            check("addi_r1_100", cpu_out, 8'd100);
      step(alu(4'h2, 3'd5, 3'd1, 3'd1));  check("mul_wrap", cpu_out, 8'd16);
      step(Nop);                          check("nop_hold", cpu_out, 8'd16);
      step(alu(4'h0, 3'd1, 3'd1, 3'd1));  check("add_self_double", cpu_out, 8'hC8);
      step(rdc(3'd3));                    check("read_r3", cpu_out, 8'd2);

      // A = 1..9, B = identity
      for (int n = 0; n < 9; n++) step(tload(5'(n), 7'(n + 1)));
      step(tload(5'd9, 7'd1));
      step(tload(5'd13, 7'd1));
      step(tload(5'd17, 7'd1));
      step(Oper);                         check("oper_done", {7'd0, done}, 8'd1);
      check("oper_out_hold", cpu_out, 8'd2);
      step(rdt(5'd4));                    check("ident_t4", cpu_out, 8'd5);
      step(tload(5'd9, 7'd1));            check("load_clears_done", {7'd0, done}, 8'd0);

      // B = 1..9, so A*B = A*A
      for (int n = 0; n < 9; n++) step(tload(5'(n + 9), 7'(n + 1)));
      step(Oper);
      step(rdt(5'd0));                    check("aa_t0", cpu_out, 8'd30);
      step(rdt(5'd4));                    check("aa_t4", cpu_out, 8'd81);
      step(rdt(5'd7));                    check("aa_t7", cpu_out, 8'd126);
      step(rdt(5'd8));                    check("aa_t8", cpu_out, ExpT8);
      step(rdt(5'd9));                    check("b_unchanged", cpu_out, 8'd1);

      step(tload(5'd2, 7'h7F));
      step(rdt(5'd2));                    check("load_sign_ext", cpu_out, 8'hFF);

      for (int n = 0; n < 18; n++) step(tload(5'(n), 7'd50));
      step(Oper);
      step(rdt(5'd0));                    check("all50_t0", cpu_out, ExpAll50);
      step(rdt(5'd8));                    check("all50_t8", cpu_out, ExpAll50);

      step(alu(4'hB, 3'd6, 3'd5, 3'd0));  check("movc_out_hold", cpu_out, ExpAll50);
      step(rdc(3'd6));                    check("movc_r6", cpu_out, 8'd16);
      step(c2t(5'd20, 3'd6));
      step(t2c(3'd7, 5'd20));             check("t20_reads_zero", cpu_out, 8'd0);
      step(c2t(5'd3, 3'd6));
      step(rdt(5'd3));                    check("c2t_t3", cpu_out, 8'd16);
      step(mvt(5'd1, 5'd3));
      step(t2c(3'd2, 5'd1));              check("mvt_t2c", cpu_out, 8'd16);
      step(rdc(3'd2));                    check("t2c_r2", cpu_out, 8'd16);

      step(Rst);                          check("rst_op_out", cpu_out, 8'd0);
      step(rdc(3'd5));                    check("rst_op_r5", cpu_out, 8'd0);
      step(rdt(5'd3));                    check("rst_op_t3", cpu_out, 8'd0);

      step(addi(3'd1, 8'd7));             check("post_rst_addi", cpu_out, 8'd7);
      rst = 1'b1;
      step(alu(4'h0, 3'd3, 3'd1, 3'd1));  check("rst_pin_out", cpu_out, 8'd0);
      rst = 1'b0;
      step(rdc(3'd3));                    check("rst_pin_r3", cpu_out, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
